// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader
// Accepts bitstream words over a valid/ready handshake and serializes them
// MSB-first onto the configuration chain head. It stops after exactly
// CHAIN_LEN bits and drives a per-cycle shift enable used to gate prog_clk.
// Optional feature macro: CCFF_TAIL_CHECK_EN. When defined, the loader spends
// one extra CHECK cycle comparing ccff_tail against the first bit shifted in.
// The default build (macro undefined) has no CHECK state and ties error to 0.
module ccff_bitstream_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 32
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              start,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              chain_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int BIT_W = $clog2(WORD_W + 1);
  localparam int TOT_W = $clog2(CHAIN_LEN + 1);

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [TOT_W-1:0] TOT_LAST = TOT_W'(CHAIN_LEN - 1);
  localparam logic [TOT_W-1:0] TOT_ONE  = TOT_W'(1);

`ifdef CCFF_TAIL_CHECK_EN
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_WORD = 3'd1,
    ST_SHIFT     = 3'd2,
    ST_CHECK     = 3'd3,
    ST_DONE      = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_WORD = 3'd1,
    ST_SHIFT     = 3'd2,
    ST_DONE      = 3'd4
  } state_t;
`endif

  state_t            state_r;
  state_t            state_next_s;
  logic [WORD_W-1:0] shreg_r;
  logic [BIT_W-1:0]  bit_cnt_r;
  logic [TOT_W-1:0]  total_cnt_r;
  logic              ready_next_s;
  logic              en_next_s;
  logic              busy_next_s;
  logic              done_next_s;
  logic              accept_s;

  // word_ready is a flop that is high exactly while in WAIT_WORD
  assign accept_s  = word_valid & word_ready;
  // the head bit comes straight from the shift register flop
  assign ccff_head = shreg_r[WORD_W-1];

  // State register
  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: total bit count takes priority over the per-word count
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_next_s = ST_WAIT_WORD;
        else       state_next_s = ST_IDLE;
      end
      ST_WAIT_WORD: begin
        if (accept_s) state_next_s = ST_SHIFT;
        else          state_next_s = ST_WAIT_WORD;
      end
      ST_SHIFT: begin
        if (total_cnt_r == TOT_LAST) begin
`ifdef CCFF_TAIL_CHECK_EN
          state_next_s = ST_CHECK;
`else
          state_next_s = ST_DONE;
`endif
        end else if (bit_cnt_r == BIT_LAST) begin
          state_next_s = ST_WAIT_WORD;
        end else begin
          state_next_s = ST_SHIFT;
        end
      end
`ifdef CCFF_TAIL_CHECK_EN
      ST_CHECK: state_next_s = ST_DONE;
`endif
      ST_DONE:  state_next_s = ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // Output decode from the next state so the registered outputs line up with the state
  always_comb begin
    ready_next_s = 1'b0;
    en_next_s    = 1'b0;
    busy_next_s  = 1'b0;
    done_next_s  = 1'b0;
    case (state_next_s)
      ST_IDLE: begin
        busy_next_s = 1'b0;
      end
      ST_WAIT_WORD: begin
        ready_next_s = 1'b1;
        busy_next_s  = 1'b1;
      end
      ST_SHIFT: begin
        en_next_s   = 1'b1;
        busy_next_s = 1'b1;
      end
`ifdef CCFF_TAIL_CHECK_EN
      ST_CHECK: begin
        busy_next_s = 1'b1;
      end
`endif
      ST_DONE: begin
        busy_next_s = 1'b1;
        done_next_s = 1'b1;
      end
      default: begin
        busy_next_s = 1'b0;
      end
    endcase
  end

  // Registered handshake and status outputs
  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      word_ready <= 1'b0;
      chain_en   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      word_ready <= ready_next_s;
      chain_en   <= en_next_s;
      busy       <= busy_next_s;
      done       <= done_next_s;
    end
  end

  // Shift register and bit counters; counters stop at their terminal value
  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      shreg_r     <= '0;
      bit_cnt_r   <= '0;
      total_cnt_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            bit_cnt_r   <= '0;
            total_cnt_r <= '0;
          end
        end
        ST_WAIT_WORD: begin
          if (accept_s) begin
            shreg_r   <= word_data;
            bit_cnt_r <= '0;
          end
        end
        ST_SHIFT: begin
          shreg_r     <= {shreg_r[WORD_W-2:0], 1'b0};
          bit_cnt_r   <= bit_cnt_r + BIT_ONE;
          total_cnt_r <= total_cnt_r + TOT_ONE;
        end
        default: begin
          shreg_r <= shreg_r;
        end
      endcase
    end
  end

`ifdef CCFF_TAIL_CHECK_EN
  logic first_bit_r;
  logic error_r;

  // Capture the first bit shifted in; flag a mismatch when it should reach the tail
  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      first_bit_r <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      if (state_r == ST_IDLE && start) begin
        error_r <= 1'b0;
      end else if (state_r == ST_CHECK && (ccff_tail != first_bit_r)) begin
        error_r <= 1'b1;
      end
      if (state_r == ST_SHIFT && total_cnt_r == '0) begin
        first_bit_r <= shreg_r[WORD_W-1];
      end
    end
  end

  assign error = error_r;
`else
  logic unused_tail_s;

  // No continuity check in this build: the tail input is intentionally ignored
  assign unused_tail_s = ccff_tail;
  assign error         = 1'b0;
`endif

endmodule

// File: doc/ccff_bitstream_loader.md
# ccff_bitstream_loader

Configuration-chain loader that sits directly upstream of the I/O and logic tiles' `ccff_head` input. It accepts bitstream words from the SoC side over a valid/ready handshake, serializes them MSB-first onto `ccff_head`, and asserts a per-cycle shift enable that the top level uses to gate `prog_clk` into the chain. It stops after exactly `CHAIN_LEN` bits and can optionally verify chain continuity through `ccff_tail`.

## Interface
- `CHAIN_LEN`, 64: total configuration bits in the chain (≥1).
- `WORD_W`, 32: bitstream word width (≥2).

- `prog_clk`  in  1  programming clock; all state is on the rising edge.
- `prog_rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level-sampled in IDLE; begins a load.
- `word_data`  in  WORD_W  bitstream word; MSB is shifted first.
- `word_valid`  in  1  `word_data` is valid.
- `word_ready`  out  1  loader accepts a word this cycle.
- `ccff_head`  out  1  serial bit to the chain head (register output).
- `chain_en`  out  1  chain must capture `ccff_head` on the next `prog_clk` edge.
- `ccff_tail`  in  1  serial output of the chain tail.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  single-cycle pulse when the load completes.
- `error`  out  1  tail-check failure; sticky until the next accepted `start`.

## Operation
- States: IDLE, WAIT_WORD, SHIFT, CHECK (macro only), DONE.
- IDLE: `busy`=0. When `start`=1, clear the counters, clear `error`, and go to WAIT_WORD.
- WAIT_WORD: `word_ready`=1 and `chain_en`=0.
  - On `word_valid`&`word_ready`, load the shift register with `word_data`, set `bit_cnt`=0, and go to SHIFT.
  - The SoC may stall indefinitely. The chain holds its contents because `chain_en`=0.
- SHIFT: `chain_en`=1. `ccff_head` is the shift-register MSB.
  - Each cycle, shift left by one and increment both `bit_cnt` and `total_cnt`.
  - When `total_cnt` reaches `CHAIN_LEN`, go to CHECK (macro defined) or DONE. The remaining bits of a partial last word are discarded.
  - Otherwise, when `bit_cnt` reaches `WORD_W`, go to WAIT_WORD.
- DONE: `done`=1 for one cycle, then return to IDLE.
- Word count is ceil(`CHAIN_LEN`/`WORD_W`). No word is requested beyond that count.
- Counter widths: `bit_cnt` is $clog2(`WORD_W`+1); `total_cnt` is $clog2(`CHAIN_LEN`+1). Neither counter wraps.
- `start` is ignored while `busy`=1. There is no abort; only reset cancels a load.
- Reset mid-load: all state returns to reset values immediately. The chain contents are undefined, and a full reload is required.

## Timing
- Reset values: `word_ready`=0, `ccff_head`=0, `chain_en`=0, `busy`=0, `done`=0, `error`=0, state=IDLE.
- A handshake in cycle t produces the first shifted bit in cycle t+1.
- `chain_en` is never high for more than `CHAIN_LEN` cycles per load.
- With no stalls, `start` sampled at cycle 0 gives `done` at cycle 1 + ceil(`CHAIN_LEN`/`WORD_W`) + `CHAIN_LEN`. Add 1 cycle if the macro is defined.
- `word_ready` and `chain_en` are never high in the same cycle.

## Configuration
- `CCFF_TAIL_CHECK_EN`
  - Defined: the loader captures the first bit shifted in. After the final shift it enters CHECK for one cycle and samples `ccff_tail`. On the `CHAIN_LEN`-th shift the first bit is at the last chain flip-flop. If `ccff_tail` differs from the captured bit, `error` is set, and it is set in the same cycle that CHECK transitions to DONE.
  - Not defined: the CHECK state, the capture register and the comparator are absent. `error` is tied to 0, and `ccff_tail` is unused.

## Test plan
All cases use `CHAIN_LEN`=40, `WORD_W`=32, and a 40-bit bench chain model that shifts when `chain_en`=1.

- Load words 0xA5A5_A5A5 and 0xF000_0000 with no stalls. Required: 40 `chain_en` cycles; the chain holds A5A5A5A5 followed by F0; `done` at cycle 43 after `start` (44 with the macro).
- Hold `word_valid` low for 10 cycles before the second word. Required: `chain_en`=0 throughout the stall, chain contents unchanged, `done` delayed by exactly 10 cycles.
- Assert `start` during SHIFT. Required: ignored, no extra word requested, exactly one `done` pulse.
- Assert `prog_rst_n`=0 after bit 20. Required: all outputs return to reset values asynchronously; a subsequent `start` reloads the full 40 bits correctly.
- Macro defined, bench chain broken (`ccff_tail` stuck at 0), first bit = 1. Required: `error`=1 alongside `done`, held until the next `start`; with an intact chain, `error`=0.
- Macro defined, first word 0x0000_0000 and an intact chain. Required: `error`=0, confirming the comparison is against the first bit shifted in and not a fixed value.
